// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single memory controller.
// Grant to mc_valid 1 cycle, mc_ready to response strobe 1 cycle; rdy=0 freezes everything.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [2:0]  ls_type,
    input  logic [31:0] ls_data,
    output logic        ls_ready,
    output logic [31:0] ls_result,
    output logic        mc_valid,
    output logic        mc_wr,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_type,
    output logic [31:0] mc_data,
    input  logic        mc_ready,
    input  logic [31:0] mc_result
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY_IF, S_BUSY_LS, S_RESP} state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_LS = 1'b1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic        r_drop;
    logic        r_if_ready;
    logic        r_ls_ready;
    logic [31:0] r_if_data;
    logic [31:0] r_ls_result;
    logic [31:0] r_addr;
    logic        r_wr;
    logic [2:0]  r_type;
    logic [31:0] r_data;
    logic        w_if_req;
    logic        w_grant_if;
    logic        w_grant_ls;
    logic [31:0] w_ls_ext;

    // A fetch being flushed in the same cycle is not a request at all.
    assign w_if_req = if_valid & ~if_flush;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_ls  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ls_valid && w_if_req) begin
                    if (r_last_grant == GNT_IF) w_grant_ls = 1'b1;
                    else                        w_grant_if = 1'b1;
                end else if (ls_valid) begin
                    w_grant_ls = 1'b1;
                end else if (w_if_req) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_ls)      w_state_nxt = S_BUSY_LS;
                else if (w_grant_if) w_state_nxt = S_BUSY_IF;
            end
            S_BUSY_IF, S_BUSY_LS: begin
                if (mc_ready) w_state_nxt = S_RESP;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ls_ext = mc_result;
        case (r_type[1:0])
            2'b00:   w_ls_ext = {{24{~r_type[2] & mc_result[7]}}, mc_result[7:0]};
            2'b01:   w_ls_ext = {{16{~r_type[2] & mc_result[15]}}, mc_result[15:0]};
            default: w_ls_ext = mc_result;
        endcase
        if (r_wr) w_ls_ext = 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= GNT_IF;
            r_drop       <= 1'b0;
            r_if_ready   <= 1'b0;
            r_ls_ready   <= 1'b0;
            r_if_data    <= 32'h0;
            r_ls_result  <= 32'h0;
            r_addr       <= 32'h0;
            r_wr         <= 1'b0;
            r_type       <= 3'b000;
            r_data       <= 32'h0;
        end else if (rdy) begin
            r_state    <= w_state_nxt;
            r_if_ready <= 1'b0;
            r_ls_ready <= 1'b0;
            if (w_grant_ls) begin
                r_addr       <= ls_addr;
                r_wr         <= ls_wr;
                r_type       <= ls_type;
                r_data       <= ls_data;
                r_last_grant <= GNT_LS;
            end
            if (w_grant_if) begin
                r_addr       <= if_addr;
                r_wr         <= 1'b0;
                r_type       <= 3'b010;
                r_data       <= 32'h0;
                r_last_grant <= GNT_IF;
            end
            // A flushed fetch still completes on the bus; only its strobe is suppressed.
            if (r_state == S_BUSY_IF) begin
                r_drop <= r_drop | if_flush;
                if (mc_ready && !(r_drop || if_flush)) begin
                    r_if_data  <= mc_result;
                    r_if_ready <= 1'b1;
                end
            end
            if (r_state == S_BUSY_LS && mc_ready) begin
                r_ls_result <= w_ls_ext;
                r_ls_ready  <= 1'b1;
            end
            if (r_state == S_RESP) r_drop <= 1'b0;
        end
    end

    assign mc_valid  = (r_state == S_BUSY_IF) || (r_state == S_BUSY_LS);
    assign mc_addr   = r_addr;
    assign mc_wr     = r_wr;
    assign mc_type   = r_type;
    assign mc_data   = r_data;
    assign if_ready  = r_if_ready;
    assign ls_ready  = r_ls_ready;
    assign if_data   = r_if_data;
    assign ls_result = r_ls_result;

endmodule
